// File: rtl/id2exe_operand_stage_pkg.sv
// Shared widths, ALU command encodings and the ID/EXE pipeline record.
package id2exe_operand_stage_pkg;

    localparam int WORD_LEN          = 32;
    localparam int EXE_CMD_LEN       = 4;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int SHAMT_LEN         = 8;

    // Command 0 is reserved for the bubble so a zeroed slot is a harmless NOP.
    localparam logic [EXE_CMD_LEN-1:0] EXE_NOP  = 4'd0;
    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD  = 4'd1;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB  = 4'd2;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND  = 4'd3;
    localparam logic [EXE_CMD_LEN-1:0] EXE_OR   = 4'd4;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XOR  = 4'd5;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLL  = 4'd6;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRL  = 4'd7;
    localparam logic [EXE_CMD_LEN-1:0] EXE_MULT = 4'd8;

    typedef struct packed {
        logic                         valid;
        logic [EXE_CMD_LEN-1:0]       cmd;
        logic [WORD_LEN-1:0]          reg1;
        logic [WORD_LEN-1:0]          reg2;
        logic [WORD_LEN-1:0]          imm;
        logic                         use_imm;
        logic [SHAMT_LEN-1:0]         shamt;
        logic [REG_FILE_ADDR_LEN-1:0] src1;
        logic [REG_FILE_ADDR_LEN-1:0] src2;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic                         wb_en;
        logic                         mem_read;
        logic                         mem_write;
    } id_exe_t;

endpackage

// File: rtl/forwarding_unit.sv
// Operand bypass mux: picks the youngest in-flight write to src, falling back
// to the register-file value. MEM is younger than WB, so it wins.
module forwarding_unit
    import id2exe_operand_stage_pkg::*;
(
    input  logic [REG_FILE_ADDR_LEN-1:0] src_i,
    input  logic [WORD_LEN-1:0]          reg_val_i,
    input  logic                         mem_wb_en_i,
    input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest_i,
    input  logic [WORD_LEN-1:0]          mem_result_i,
    input  logic                         wb_wb_en_i,
    input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest_i,
    input  logic [WORD_LEN-1:0]          wb_value_i,
    output logic [WORD_LEN-1:0]          val_o
);

    always_comb begin
        val_o = reg_val_i;
        // r0 is hardwired zero, so a write targeting it must never be bypassed.
        if (src_i != '0) begin
            if (mem_wb_en_i && (mem_dest_i == src_i)) begin
                val_o = mem_result_i;
            end else if (wb_wb_en_i && (wb_dest_i == src_i)) begin
                val_o = wb_value_i;
            end
        end
    end

endmodule

// File: rtl/id2exe_operand_stage.sv
// ID/EXE pipeline register with load-use bubble insertion and MEM/WB operand
// forwarding feeding the ALU.
module id2exe_operand_stage
    import id2exe_operand_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [EXE_CMD_LEN-1:0]       id_exe_cmd,
    input  logic [WORD_LEN-1:0]          id_reg1,
    input  logic [WORD_LEN-1:0]          id_reg2,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_src1,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_src2,
    input  logic [WORD_LEN-1:0]          id_imm,
    input  logic                         id_use_imm,
    input  logic [SHAMT_LEN-1:0]         id_shamt,
    input  logic [REG_FILE_ADDR_LEN-1:0] id_dest,
    input  logic                         id_wb_en,
    input  logic                         id_mem_read,
    input  logic                         id_mem_write,
    input  logic                         flush,
    input  logic                         hold,
    input  logic                         mem_wb_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
    input  logic [WORD_LEN-1:0]          mem_result,
    input  logic                         wb_wb_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
    input  logic [WORD_LEN-1:0]          wb_value,
    output logic                         exe_valid,
    output logic [EXE_CMD_LEN-1:0]       exe_cmd,
    output logic [WORD_LEN-1:0]          exe_val1,
    output logic [WORD_LEN-1:0]          exe_val2,
    output logic [SHAMT_LEN-1:0]         exe_sll_amount,
    output logic [WORD_LEN-1:0]          exe_store_val,
    output logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
    output logic                         exe_wb_en,
    output logic                         exe_mem_read,
    output logic                         exe_mem_write,
    output logic                         stall_out
);

    id_exe_t             stage_q;
    id_exe_t             stage_d;
    id_exe_t             id_fields;
    logic                load_use;
    logic [WORD_LEN-1:0] fwd1_val;
    logic [WORD_LEN-1:0] fwd2_val;

    always_comb begin
        id_fields           = '0;
        id_fields.valid     = 1'b1;
        id_fields.cmd       = id_exe_cmd;
        id_fields.reg1      = id_reg1;
        id_fields.reg2      = id_reg2;
        id_fields.imm       = id_imm;
        id_fields.use_imm   = id_use_imm;
        id_fields.shamt     = id_shamt;
        id_fields.src1      = id_src1;
        id_fields.src2      = id_src2;
        id_fields.dest      = id_dest;
        id_fields.wb_en     = id_wb_en;
        id_fields.mem_read  = id_mem_read;
        id_fields.mem_write = id_mem_write;
    end

    // A load in EXE has no data yet, so a dependent consumer must wait one slot
    // and pick the value up from the MEM bypass on its second presentation.
    always_comb begin
        load_use = id_valid && stage_q.valid && stage_q.mem_read &&
                   (stage_q.dest != '0) &&
                   ((stage_q.dest == id_src1) ||
                    ((stage_q.dest == id_src2) && !id_use_imm));
    end

    always_comb begin
        stage_d = stage_q;
        if (hold) begin
            stage_d = stage_q;
        end else if (flush || !id_valid || load_use) begin
            stage_d = '0;
        end else begin
            stage_d = id_fields;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stall_out = hold | (load_use & ~flush);

    forwarding_unit u_fwd_src1 (
        .src_i        (stage_q.src1),
        .reg_val_i    (stage_q.reg1),
        .mem_wb_en_i  (mem_wb_en),
        .mem_dest_i   (mem_dest),
        .mem_result_i (mem_result),
        .wb_wb_en_i   (wb_wb_en),
        .wb_dest_i    (wb_dest),
        .wb_value_i   (wb_value),
        .val_o        (fwd1_val)
    );

    forwarding_unit u_fwd_src2 (
        .src_i        (stage_q.src2),
        .reg_val_i    (stage_q.reg2),
        .mem_wb_en_i  (mem_wb_en),
        .mem_dest_i   (mem_dest),
        .mem_result_i (mem_result),
        .wb_wb_en_i   (wb_wb_en),
        .wb_dest_i    (wb_dest),
        .wb_value_i   (wb_value),
        .val_o        (fwd2_val)
    );

    assign exe_valid      = stage_q.valid;
    assign exe_cmd        = stage_q.cmd;
    assign exe_val1       = fwd1_val;
    assign exe_store_val  = fwd2_val;
    assign exe_val2       = stage_q.use_imm ? stage_q.imm : fwd2_val;
    assign exe_sll_amount = stage_q.shamt;
    assign exe_dest       = stage_q.dest;
    assign exe_wb_en      = stage_q.wb_en;
    assign exe_mem_read   = stage_q.mem_read;
    assign exe_mem_write  = stage_q.mem_write;

endmodule

// File: tb/tb_id2exe_operand_stage.sv
// Scoreboard bench: a driver issues directed then random cycles and queues the
// expected ALU-side view; a monitor pops and compares one entry per cycle.
module tb_id2exe_operand_stage;
    import id2exe_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_exe_cmd;
    logic [31:0] id_reg1, id_reg2, id_imm;
    logic [4:0]  id_src1, id_src2, id_dest;
    logic        id_use_imm;
    logic [7:0]  id_shamt;
    logic        id_wb_en, id_mem_read, id_mem_write;
    logic        flush, hold;
    logic        mem_wb_en, wb_wb_en;
    logic [4:0]  mem_dest, wb_dest;
    logic [31:0] mem_result, wb_value;
    logic        exe_valid;
    logic [3:0]  exe_cmd;
    logic [31:0] exe_val1, exe_val2, exe_store_val;
    logic [7:0]  exe_sll_amount;
    logic [4:0]  exe_dest;
    logic        exe_wb_en, exe_mem_read, exe_mem_write;
    logic        stall_out;

    always #5 clk = ~clk;

    id2exe_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_exe_cmd(id_exe_cmd),
        .id_reg1(id_reg1), .id_reg2(id_reg2), .id_src1(id_src1), .id_src2(id_src2),
        .id_imm(id_imm), .id_use_imm(id_use_imm), .id_shamt(id_shamt),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush(flush), .hold(hold),
        .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_valid(exe_valid), .exe_cmd(exe_cmd), .exe_val1(exe_val1),
        .exe_val2(exe_val2), .exe_sll_amount(exe_sll_amount),
        .exe_store_val(exe_store_val), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
        .stall_out(stall_out)
    );

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] r1, r2, imm;
        logic [4:0]  s1, s2, dest;
        logic        ui;
        logic [7:0]  sh;
        logic        wb, rd, wr;
    } ins_t;

    typedef struct packed {
        int          cyc;
        logic        valid;
        logic [3:0]  cmd;
        logic [31:0] v1, v2, sv;
        logic [7:0]  sh;
        logic [4:0]  dest;
        logic        wb, rd, wr, stall;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;

    // Reference model: the instruction currently sitting in EXE (or none).
    ins_t m_ins;
    bit   m_valid;

    function automatic ins_t mk(input logic [3:0] cmd, input logic [4:0] s1,
                                input logic [31:0] r1, input logic [4:0] s2,
                                input logic [31:0] r2, input logic [4:0] dest,
                                input logic ui, input logic [31:0] imm,
                                input logic [7:0] sh, input logic wb,
                                input logic rd, input logic wr);
        ins_t x;
        x.cmd = cmd; x.s1 = s1; x.r1 = r1; x.s2 = s2; x.r2 = r2; x.dest = dest;
        x.ui = ui; x.imm = imm; x.sh = sh; x.wb = wb; x.rd = rd; x.wr = wr;
        return x;
    endfunction

    // Value an instruction should see for a source register given the writes in flight.
    function automatic logic [31:0] operand(input logic [4:0] s, input logic [31:0] rf,
                                            input logic me, input logic [4:0] md,
                                            input logic [31:0] mr, input logic we,
                                            input logic [4:0] wd, input logic [31:0] wv);
        if (s == 5'd0) return rf;
        if (me && md == s) return mr;
        if (we && wd == s) return wv;
        return rf;
    endfunction

    task automatic cycle(input ins_t ins, input logic idv, input logic fl,
                         input logic hd, input logic rs,
                         input logic me, input logic [4:0] md, input logic [31:0] mr,
                         input logic we, input logic [4:0] wd, input logic [31:0] wv);
        exp_t e;
        bit   waits_on_load;
        rst = rs; id_valid = idv; flush = fl; hold = hd;
        id_exe_cmd = ins.cmd; id_reg1 = ins.r1; id_reg2 = ins.r2; id_imm = ins.imm;
        id_src1 = ins.s1; id_src2 = ins.s2; id_dest = ins.dest; id_use_imm = ins.ui;
        id_shamt = ins.sh; id_wb_en = ins.wb; id_mem_read = ins.rd; id_mem_write = ins.wr;
        mem_wb_en = me; mem_dest = md; mem_result = mr;
        wb_wb_en = we; wb_dest = wd; wb_value = wv;

        waits_on_load = idv && m_valid && m_ins.rd && m_ins.dest != 5'd0 &&
                        (m_ins.dest == ins.s1 || (m_ins.dest == ins.s2 && !ins.ui));
        e = '0;
        e.cyc   = cyc_n;
        e.stall = hd || (waits_on_load && !fl);
        if (m_valid) begin
            e.valid = 1'b1;
            e.cmd   = m_ins.cmd;
            e.v1    = operand(m_ins.s1, m_ins.r1, me, md, mr, we, wd, wv);
            e.sv    = operand(m_ins.s2, m_ins.r2, me, md, mr, we, wd, wv);
            e.v2    = m_ins.ui ? m_ins.imm : e.sv;
            e.sh    = m_ins.sh;
            e.dest  = m_ins.dest;
            e.wb    = m_ins.wb;
            e.rd    = m_ins.rd;
            e.wr    = m_ins.wr;
        end
        exp_q.push_back(e);

        @(posedge clk);
        if (rs) begin
            m_valid = 1'b0; m_ins = '0;
        end else if (!hd) begin
            if (fl || !idv || waits_on_load) begin
                m_valid = 1'b0; m_ins = '0;
            end else begin
                m_valid = 1'b1; m_ins = ins;
            end
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic plain(input ins_t ins, input logic idv);
        cycle(ins, idv, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic chk(input string nm, input int c, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %0d valid=%0d cmd=%0d v1=%h v2=%h sv=%h sh=%0d dest=%0d stall=%0d",
                         e.cyc, exe_valid, exe_cmd, exe_val1, exe_val2, exe_store_val,
                         exe_sll_amount, exe_dest, stall_out);
                chk("exe_valid", e.cyc, 32'(exe_valid), 32'(e.valid));
                chk("exe_cmd", e.cyc, 32'(exe_cmd), 32'(e.cmd));
                chk("exe_val1", e.cyc, exe_val1, e.v1);
                chk("exe_val2", e.cyc, exe_val2, e.v2);
                chk("exe_store_val", e.cyc, exe_store_val, e.sv);
                chk("exe_sll_amount", e.cyc, 32'(exe_sll_amount), 32'(e.sh));
                chk("exe_dest", e.cyc, 32'(exe_dest), 32'(e.dest));
                chk("exe_wb_en", e.cyc, 32'(exe_wb_en), 32'(e.wb));
                chk("exe_mem_read", e.cyc, 32'(exe_mem_read), 32'(e.rd));
                chk("exe_mem_write", e.cyc, 32'(exe_mem_write), 32'(e.wr));
                chk("stall_out", e.cyc, 32'(stall_out), 32'(e.stall));
            end
        end
    end

    initial begin : driver
        ins_t nop, lw5, add_a, add_b, sub_dep, mult, sll, r;
        logic [3:0] cmds [9];
        cmds = '{EXE_NOP, EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_XOR,
                 EXE_SLL, EXE_SRL, EXE_MULT};
        nop = '0;
        m_ins = '0; m_valid = 1'b0;
        cycle(nop, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        exp_q.delete();
        @(negedge clk);
        // Reset state, then normal flow.
        plain(nop, 1'b0);
        add_a = mk(EXE_ADD, 5'd3, 32'd5, 5'd4, 32'd7, 5'd6, 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        plain(add_a, 1'b1);
        // Forwarding priority on a held instruction with src1=2.
        add_b = mk(EXE_ADD, 5'd2, 32'h99, 5'd0, 32'h0, 5'd7, 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        plain(add_b, 1'b1);
        cycle(nop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h11, 1'b1, 5'd2, 32'h22);
        cycle(nop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 32'h11, 1'b1, 5'd2, 32'h22);
        // Hold with flush: registers kept.
        cycle(add_a, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        add_b = mk(EXE_ADD, 5'd0, 32'h55, 5'd0, 32'h66, 5'd7, 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        plain(add_b, 1'b1);
        cycle(nop, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        // Load-use on src2, then the replay picks up the load from MEM.
        lw5 = mk(EXE_ADD, 5'd1, 32'h100, 5'd0, 32'h0, 5'd5, 1'b1, 32'h4, 8'd0, 1'b1, 1'b1, 1'b0);
        sub_dep = mk(EXE_SUB, 5'd1, 32'h10, 5'd5, 32'h3, 5'd8, 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        plain(lw5, 1'b1);
        plain(sub_dep, 1'b1);
        plain(sub_dep, 1'b1);
        cycle(nop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        // Immediate consumer of the load: no stall.
        plain(lw5, 1'b1);
        sub_dep.ui = 1'b1; sub_dep.imm = 32'h40;
        plain(sub_dep, 1'b1);
        // Load-use together with flush: bubble, no stall.
        plain(lw5, 1'b1);
        sub_dep.ui = 1'b0;
        cycle(sub_dep, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        // Reset while holding a MULT.
        mult = mk(EXE_MULT, 5'd9, 32'h3, 5'd10, 32'h4, 5'd11, 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        plain(mult, 1'b1);
        cycle(nop, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        // Shift with immediate.
        sll = mk(EXE_SLL, 5'd12, 32'h1, 5'd13, 32'h2, 5'd14, 1'b1, 32'hFFFF_FFF0, 8'd4, 1'b1, 1'b0, 1'b0);
        plain(sll, 1'b1);
        plain(nop, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            r = mk(cmds[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), $urandom(),
                   5'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 3) == 0), $urandom(), 8'($urandom()),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 5) == 0));
            cycle(r, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
        end
        plain(nop, 1'b0);

        for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
        #5;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
